core_cmd_scheduler: RTL and testbench

Sequences host commands into the CVA6 core's command/state port. A small command FIFO sits between the host-side register interface and the core. The block issues one command at a time with a valid/ready handshake and hands I/O ownership to the core through `io_switch_o`. It then tracks the core's idle pin to detect completion, and can abort a hung command with a watchdog. It sits in the SoC wrapper between the host bridge and the `ariane` instance.

---
 rtl/core_cmd_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_core_cmd_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_cmd_scheduler.sv
// Host-to-core command scheduler: command FIFO, single-outstanding issue FSM, idle tracking and abort.
// Optional watchdog / ERROR state enabled by defining CMD_SCHED_TIMEOUT_EN.
module core_cmd_scheduler #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned OP_W       = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT_W  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          host_valid_i,
    output logic                          host_ready_o,
    input  logic [OP_W-1:0]               host_op_i,
    input  logic [DATA_W-1:0]             host_data_i,
    output logic                          core_cmd_valid_o,
    input  logic                          core_cmd_ready_i,
    output logic [OP_W-1:0]               core_cmd_op_o,
    output logic [DATA_W-1:0]             core_cmd_data_o,
    input  logic                          core_idle_i,
    output logic                          io_switch_o,
    input  logic [TIMEOUT_W-1:0]          timeout_limit_i,
    input  logic                          abort_i,
    input  logic                          err_clr_i,
    output logic                          busy_o,
    output logic                          done_pulse_o,
    output logic                          err_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [31:0]                   cmd_cnt_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_IDLE = 3'd3,
        S_DONE      = 3'd4,
        S_ERROR     = 3'd5
    } state_e;

    state_e             state_q, state_d;
    cmd_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q;
    logic               push_c, pop_c;
    logic               timeout_c;
    cmd_t               cmd_q;
    logic               valid_q, io_q, busy_q, done_q;
    logic [31:0]        cmd_cnt_q;

    // Ready comes from the registered occupancy; abort vetoes it combinationally.
    assign host_ready_o = ready_q && !abort_i;
    assign push_c       = host_valid_i && host_ready_o;

    always_comb begin
        if (abort_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d < CNT_W'(FIFO_DEPTH));
            if (abort_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: occupancy alone defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= cmd_t'{op: host_op_i, data: host_data_i};
        end
    end

`ifdef CMD_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_q;
    logic [TIMEOUT_W-1:0] wd_inc_c;
    logic                 err_q;

    assign wd_inc_c  = wd_q + TIMEOUT_W'(1);
    // Fires on the cycle whose increment reaches the limit, so ERROR is entered limit cycles after WAIT_BUSY entry.
    assign timeout_c = (timeout_limit_i != '0) && (wd_inc_c == timeout_limit_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= (state_d == S_ERROR);
            if (state_q == S_ISSUE) begin
                wd_q <= '0;
            end else if (state_q == S_WAIT_BUSY || state_q == S_WAIT_IDLE) begin
                wd_q <= wd_inc_c;
            end
        end
    end

    assign err_o = err_q;
`else
    logic unused_wd_c;

    assign unused_wd_c = ^{timeout_limit_i, err_clr_i};
    assign timeout_c   = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (core_cmd_ready_i) state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!core_idle_i) state_d = S_WAIT_IDLE;
                if (timeout_c)    state_d = S_ERROR;
            end
            S_WAIT_IDLE: begin
                // Completion takes precedence over a coincident timeout.
                if (timeout_c)   state_d = S_ERROR;
                if (core_idle_i) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
`ifdef CMD_SCHED_TIMEOUT_EN
                if (err_clr_i) state_d = S_IDLE;
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
            pop_c   = 1'b0;
        end
    end

    // Outputs are registered images of the next state so they change together with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            io_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cmd_cnt_q <= '0;
            cmd_q     <= '0;
        end else begin
            valid_q <= (state_d == S_ISSUE);
            io_q    <= (state_d == S_WAIT_BUSY) || (state_d == S_WAIT_IDLE);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            if (state_d == S_DONE) cmd_cnt_q <= cmd_cnt_q + 32'd1;
            if (pop_c)             cmd_q     <= mem_q[rd_ptr_q];
        end
    end

    assign core_cmd_valid_o = valid_q;
    assign core_cmd_op_o    = cmd_q.op;
    assign core_cmd_data_o  = cmd_q.data;
    assign io_switch_o      = io_q;
    assign busy_o           = busy_q;
    assign done_pulse_o     = done_q;
    assign fifo_count_o     = count_q;
    assign cmd_cnt_o        = cmd_cnt_q;

endmodule

// File: tb/tb_core_cmd_scheduler.sv
// Self-checking bench for core_cmd_scheduler: randomized host/core traffic against a queue-based model.
module tb_core_cmd_scheduler;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TW     = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              host_valid_i = 1'b0;
    logic              host_ready_o;
    logic [OP_W-1:0]   host_op_i = '0;
    logic [DATA_W-1:0] host_data_i = '0;
    logic              core_cmd_valid_o;
    logic              core_cmd_ready_i = 1'b0;
    logic [OP_W-1:0]   core_cmd_op_o;
    logic [DATA_W-1:0] core_cmd_data_o;
    logic              core_idle_i = 1'b1;
    logic              io_switch_o;
    logic [TW-1:0]     timeout_limit_i = '0;
    logic              abort_i = 1'b0;
    logic              err_clr_i = 1'b0;
    logic              busy_o;
    logic              done_pulse_o;
    logic              err_o;
    logic [2:0]        fifo_count_o;
    logic [31:0]       cmd_cnt_o;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
    } cmd_s;

    cmd_s mq[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;

    core_cmd_scheduler #(.DATA_W(DATA_W), .OP_W(OP_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_W(TW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
        .host_op_i(host_op_i), .host_data_i(host_data_i),
        .core_cmd_valid_o(core_cmd_valid_o), .core_cmd_ready_i(core_cmd_ready_i),
        .core_cmd_op_o(core_cmd_op_o), .core_cmd_data_o(core_cmd_data_o),
        .core_idle_i(core_idle_i), .io_switch_o(io_switch_o),
        .timeout_limit_i(timeout_limit_i), .abort_i(abort_i), .err_clr_i(err_clr_i),
        .busy_o(busy_o), .done_pulse_o(done_pulse_o), .err_o(err_o),
        .fifo_count_o(fifo_count_o), .cmd_cnt_o(cmd_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Presents one command for a single cycle; reports whether ready was high.
    task automatic push_cmd(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] d, output bit acc);
        host_valid_i = 1'b1;
        host_op_i    = op;
        host_data_i  = d;
        #1;
        acc = host_ready_o;
        step();
        host_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (core_cmd_valid_o !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        ok = (core_cmd_valid_o === 1'b1);
    endtask

    // Core-side responder: accepts the presented command, runs for runtime cycles, then goes idle.
    task automatic run_core(input int ready_dly, input int runtime,
                            output logic [OP_W-1:0] op, output logic [DATA_W-1:0] data,
                            output int done_len, output bit ok);
        wait_valid(ok);
        done_len = 0;
        op = '0;
        data = '0;
        if (ok) begin
            repeat (ready_dly) step();
            op = core_cmd_op_o;
            data = core_cmd_data_o;
            core_cmd_ready_i = 1'b1;
            step();
            core_cmd_ready_i = 1'b0;
            core_idle_i = 1'b0;
            step();
            repeat (runtime) step();
            core_idle_i = 1'b1;
            step();
            while (done_pulse_o === 1'b1 && done_len < 5) begin
                done_len++;
                step();
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (core_cmd_valid_o !== 1'b0 || io_switch_o !== 1'b0 || busy_o !== 1'b0 || done_pulse_o !== 1'b0)
            begin failures++; $display("FAIL rst_ctrl got v=%b io=%b busy=%b done=%b exp 0", core_cmd_valid_o, io_switch_o, busy_o, done_pulse_o); end
        checks++; if (host_ready_o !== 1'b0 || err_o !== 1'b0 || fifo_count_o !== 3'd0 || cmd_cnt_o !== 32'd0)
            begin failures++; $display("FAIL rst_status got rdy=%b err=%b cnt=%0d cmd=%0d exp 0", host_ready_o, err_o, fifo_count_o, cmd_cnt_o); end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        checks++; if (host_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", host_ready_o); end
    endtask

    task automatic test_single();
        bit acc;
        push_cmd(4'd3, 64'hDEAD_BEEF, acc);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL single_acc got=%b exp=1", acc); end
        checks++; if (fifo_count_o !== 3'd1 || core_cmd_valid_o !== 1'b0)
            begin failures++; $display("FAIL single_t1 got cnt=%0d v=%b exp cnt=1 v=0", fifo_count_o, core_cmd_valid_o); end
        step();
        checks++; if (core_cmd_valid_o !== 1'b1 || core_cmd_op_o !== 4'd3 || core_cmd_data_o !== 64'hDEAD_BEEF)
            begin failures++; $display("FAIL single_issue got v=%b op=%0d d=%h exp v=1 op=3 d=deadbeef", core_cmd_valid_o, core_cmd_op_o, core_cmd_data_o); end
        core_cmd_ready_i = 1'b1;
        step();
        core_cmd_ready_i = 1'b0;
        checks++; if (core_cmd_valid_o !== 1'b0 || io_switch_o !== 1'b1)
            begin failures++; $display("FAIL single_hs got v=%b io=%b exp v=0 io=1", core_cmd_valid_o, io_switch_o); end
        core_idle_i = 1'b0;
        repeat (3) step();
        checks++; if (io_switch_o !== 1'b1 || done_pulse_o !== 1'b0)
            begin failures++; $display("FAIL single_run got io=%b done=%b exp io=1 done=0", io_switch_o, done_pulse_o); end
        core_idle_i = 1'b1;
        step();
        exp_cnt++;
        checks++; if (done_pulse_o !== 1'b1 || cmd_cnt_o !== 32'(exp_cnt) || io_switch_o !== 1'b0)
            begin failures++; $display("FAIL single_done got done=%b cmd=%0d io=%b exp done=1 cmd=%0d io=0", done_pulse_o, cmd_cnt_o, io_switch_o, exp_cnt); end
        step();
        checks++; if (done_pulse_o !== 1'b0 || busy_o !== 1'b0)
            begin failures++; $display("FAIL single_idle got done=%b busy=%b exp 0 0", done_pulse_o, busy_o); end
    endtask

    task automatic test_fifo_full();
        bit acc, ok;
        cmd_s c;
        logic [OP_W-1:0] op;
        logic [DATA_W-1:0] d;
        int dl;
        for (int i = 0; i < 6; i++) begin
            c.op = OP_W'(i + 1);
            c.data = {$urandom, $urandom};
            push_cmd(c.op, c.data, acc);
            // First command leaves for ISSUE; the next four fill the FIFO; the sixth must bounce.
            checks++; if (acc !== (i < 5)) begin failures++; $display("FAIL full_acc%0d got=%b exp=%b", i, acc, (i < 5)); end
            if (i < 5) mq.push_back(c);
            if (i == 0) wait_valid(ok);
        end
        checks++; if (fifo_count_o !== 3'd4 || host_ready_o !== 1'b0)
            begin failures++; $display("FAIL full_count got cnt=%0d rdy=%b exp cnt=4 rdy=0", fifo_count_o, host_ready_o); end
        for (int i = 0; i < 5; i++) begin
            run_core(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), op, d, dl, ok);
            c = mq.pop_front();
            exp_cnt++;
            checks++; if (!ok || op !== c.op || d !== c.data || dl != 1 || cmd_cnt_o !== 32'(exp_cnt))
                begin failures++; $display("FAIL full_order%0d got ok=%b op=%0d d=%h pulse=%0d cmd=%0d exp op=%0d d=%h pulse=1 cmd=%0d", i, ok, op, d, dl, cmd_cnt_o, c.op, c.data, exp_cnt); end
        end
    endtask

    task automatic test_watchdog();
        bit acc, ok;
        cmd_s c[3];
        for (int i = 0; i < 3; i++) begin
            c[i].op = 4'($urandom);
            c[i].data = {$urandom, $urandom};
            push_cmd(c[i].op, c[i].data, acc);
            if (i == 0) wait_valid(ok);
        end
        timeout_limit_i = 16'd10;
        core_cmd_ready_i = 1'b1;
        step();
        core_cmd_ready_i = 1'b0;
        checks++; if (io_switch_o !== 1'b1) begin failures++; $display("FAIL wd_entry got io=%b exp=1", io_switch_o); end
`ifdef CMD_SCHED_TIMEOUT_EN
        repeat (9) step();
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL wd_early got err=%b exp=0", err_o); end
        step();
        checks++; if (err_o !== 1'b1 || io_switch_o !== 1'b0 || fifo_count_o !== 3'd2)
            begin failures++; $display("FAIL wd_err got err=%b io=%b cnt=%0d exp err=1 io=0 cnt=2", err_o, io_switch_o, fifo_count_o); end
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        wait_valid(ok);
        checks++; if (!ok || err_o !== 1'b0 || core_cmd_op_o !== c[1].op || core_cmd_data_o !== c[1].data)
            begin failures++; $display("FAIL wd_resume got ok=%b err=%b op=%0d d=%h exp op=%0d d=%h", ok, err_o, core_cmd_op_o, core_cmd_data_o, c[1].op, c[1].data); end
`else
        err_clr_i = 1'b1;
        repeat (20) step();
        err_clr_i = 1'b0;
        checks++; if (err_o !== 1'b0 || io_switch_o !== 1'b1 || fifo_count_o !== 3'd2)
            begin failures++; $display("FAIL wd_off got err=%b io=%b cnt=%0d exp err=0 io=1 cnt=2", err_o, io_switch_o, fifo_count_o); end
`endif
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        timeout_limit_i = '0;
        checks++; if (err_o !== 1'b0 || busy_o !== 1'b0 || fifo_count_o !== 3'd0)
            begin failures++; $display("FAIL wd_abort got err=%b busy=%b cnt=%0d exp 0 0 0", err_o, busy_o, fifo_count_o); end
    endtask

    task automatic test_abort();
        bit acc, ok;
        push_cmd(4'($urandom), {$urandom, $urandom}, acc);
        wait_valid(ok);
        core_cmd_ready_i = 1'b1;
        step();
        core_cmd_ready_i = 1'b0;
        core_idle_i = 1'b0;
        step();
        for (int i = 0; i < 2; i++) push_cmd(4'($urandom), {$urandom, $urandom}, acc);
        checks++; if (fifo_count_o !== 3'd2 || io_switch_o !== 1'b1)
            begin failures++; $display("FAIL abort_pre got cnt=%0d io=%b exp cnt=2 io=1", fifo_count_o, io_switch_o); end
        abort_i = 1'b1;
        host_valid_i = 1'b1;
        host_data_i = {$urandom, $urandom};
        #1;
        checks++; if (host_ready_o !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b exp=0", host_ready_o); end
        step();
        abort_i = 1'b0;
        host_valid_i = 1'b0;
        checks++; if (fifo_count_o !== 3'd0 || core_cmd_valid_o !== 1'b0 || io_switch_o !== 1'b0 || done_pulse_o !== 1'b0 || busy_o !== 1'b0)
            begin failures++; $display("FAIL abort_next got cnt=%0d v=%b io=%b done=%b busy=%b exp all 0", fifo_count_o, core_cmd_valid_o, io_switch_o, done_pulse_o, busy_o); end
        core_idle_i = 1'b1;
        repeat (3) step();
        checks++; if (cmd_cnt_o !== 32'(exp_cnt) || fifo_count_o !== 3'd0 || core_cmd_valid_o !== 1'b0 || done_pulse_o !== 1'b0)
            begin failures++; $display("FAIL abort_after got cmd=%0d cnt=%0d v=%b done=%b exp cmd=%0d cnt=0 v=0 done=0", cmd_cnt_o, fifo_count_o, core_cmd_valid_o, done_pulse_o, exp_cnt); end
    endtask

    task automatic test_push_pop();
        bit acc, ok;
        cmd_s c;
        logic [OP_W-1:0] op;
        logic [DATA_W-1:0] d;
        int dl;
        push_cmd(4'($urandom), {$urandom, $urandom}, acc);
        wait_valid(ok);
        core_cmd_ready_i = 1'b1;
        step();
        core_cmd_ready_i = 1'b0;
        core_idle_i = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            c.op = 4'($urandom);
            c.data = {$urandom, $urandom};
            push_cmd(c.op, c.data, acc);
            mq.push_back(c);
        end
        core_idle_i = 1'b1;
        step();
        exp_cnt++;
        step();
        checks++; if (busy_o !== 1'b0 || fifo_count_o !== 3'd2)
            begin failures++; $display("FAIL pp_idle got busy=%b cnt=%0d exp busy=0 cnt=2", busy_o, fifo_count_o); end
        c.op = 4'($urandom);
        c.data = {$urandom, $urandom};
        push_cmd(c.op, c.data, acc);
        mq.push_back(c);
        checks++; if (acc !== 1'b1 || fifo_count_o !== 3'd2 || core_cmd_valid_o !== 1'b1 || core_cmd_data_o !== mq[0].data)
            begin failures++; $display("FAIL pp_count got acc=%b cnt=%0d v=%b d=%h exp acc=1 cnt=2 v=1 d=%h", acc, fifo_count_o, core_cmd_valid_o, core_cmd_data_o, mq[0].data); end
        for (int i = 0; i < 3; i++) begin
            run_core(0, 1, op, d, dl, ok);
            c = mq.pop_front();
            exp_cnt++;
            checks++; if (!ok || op !== c.op || d !== c.data || cmd_cnt_o !== 32'(exp_cnt))
                begin failures++; $display("FAIL pp_drain%0d got op=%0d d=%h cmd=%0d exp op=%0d d=%h cmd=%0d", i, op, d, cmd_cnt_o, c.op, c.data, exp_cnt); end
        end
    endtask

    task automatic test_long_run();
        bit acc, ok;
        logic [OP_W-1:0] op;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_d;
        int dl;
        exp_d = {$urandom, $urandom};
        timeout_limit_i = '0;
        push_cmd(4'd9, exp_d, acc);
        run_core(1, 1000, op, d, dl, ok);
        exp_cnt++;
        checks++; if (!ok || err_o !== 1'b0 || dl != 1 || d !== exp_d || cmd_cnt_o !== 32'(exp_cnt))
            begin failures++; $display("FAIL long_run got ok=%b err=%b pulse=%0d d=%h cmd=%0d exp err=0 pulse=1 d=%h cmd=%0d", ok, err_o, dl, d, cmd_cnt_o, exp_d, exp_cnt); end
    endtask

    task automatic test_random();
        bit acc, ok;
        cmd_s c;
        logic [OP_W-1:0] op;
        logic [DATA_W-1:0] d;
        int dl, k;
        for (int it = 0; it < 8; it++) begin
            k = int'($urandom_range(1, 4));
            for (int i = 0; i < k; i++) begin
                c.op = 4'($urandom);
                c.data = {$urandom, $urandom};
                push_cmd(c.op, c.data, acc);
                mq.push_back(c);
                checks++; if (acc !== 1'b1) begin failures++; $display("FAIL rnd_acc it=%0d i=%0d got=%b exp=1", it, i, acc); end
                repeat ($urandom_range(0, 2)) step();
            end
            for (int i = 0; i < k; i++) begin
                run_core(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), op, d, dl, ok);
                c = mq.pop_front();
                exp_cnt++;
                checks++; if (!ok || op !== c.op || d !== c.data || dl != 1 || cmd_cnt_o !== 32'(exp_cnt))
                    begin failures++; $display("FAIL rnd_cmd it=%0d i=%0d got op=%0d d=%h pulse=%0d cmd=%0d exp op=%0d d=%h pulse=1 cmd=%0d", it, i, op, d, dl, cmd_cnt_o, c.op, c.data, exp_cnt); end
            end
        end
    endtask

    task automatic test_reset_mid_issue();
        bit acc, ok;
        push_cmd(4'($urandom), {$urandom, $urandom}, acc);
        push_cmd(4'($urandom), {$urandom, $urandom}, acc);
        wait_valid(ok);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        checks++; if (core_cmd_valid_o !== 1'b0 || io_switch_o !== 1'b0 || busy_o !== 1'b0 || fifo_count_o !== 3'd0 || cmd_cnt_o !== 32'd0 || host_ready_o !== 1'b0)
            begin failures++; $display("FAIL rst_mid got v=%b io=%b busy=%b cnt=%0d cmd=%0d rdy=%b exp all 0", core_cmd_valid_o, io_switch_o, busy_o, fifo_count_o, cmd_cnt_o, host_ready_o); end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        checks++; if (fifo_count_o !== 3'd0 || busy_o !== 1'b0 || core_cmd_valid_o !== 1'b0 || host_ready_o !== 1'b1)
            begin failures++; $display("FAIL rst_release got cnt=%0d busy=%b v=%b rdy=%b exp 0 0 0 1", fifo_count_o, busy_o, core_cmd_valid_o, host_ready_o); end
    endtask

    initial begin
        #500000;
        $display("FAIL tb_timeout simulation did not finish within budget");
        $fatal(1, "tb timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_watchdog();
        test_abort();
        test_push_pop();
        test_long_run();
        test_random();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
